// File: rtl/osc_intl_multi.sv
// -----------------------------------------------------------------------------
// osc_intl_multi -- multi-channel oscillation interlock
//
// Each channel compares the magnitude of a float32 sample against its own
// float32 threshold. Every 0->1 transition of the registered compare result is
// one crossing event. A shared window counter divides time into windows of
// i_period clocks. At each window wrap, every channel with at least
// i_cnt_thresh crossings in the closing window gets one more "hit". Any other
// channel has its hit count reset to 0. When a channel's hit count reaches
// i_cycle_cnt, its interlock bit latches. The bit stays set until a rising edge
// of i_clr.
//
// Optional feature (compile-time macro OSC_FIRST_FAULT_EN):
//   Adds o_first_ch / o_first_vld. These capture the lowest channel that trips
//   while no interlock is latched. Both hold until a clear edge.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous reset, active-high
//   i_osc_en       global enable; low holds window/event/hit counters at 0
//   i_clr          interlock clear, rising-edge sensitive
//   i_data         float32 samples, channel k at [32k+31:32k]
//   i_data_thresh  float32 magnitude thresholds, channel k at [32k+31:32k]
//   i_cnt_thresh   crossings per window needed for a hit (shared)
//   i_period       window length in clocks (shared)
//   i_cycle_cnt    consecutive hit windows needed to trip (shared, 0 acts as 1)
//   o_intl         latched interlock per channel
//   o_intl_any     registered OR of o_intl (one clock behind o_intl)
//   o_first_ch     first tripping channel   (OSC_FIRST_FAULT_EN only)
//   o_first_vld    o_first_ch is valid      (OSC_FIRST_FAULT_EN only)
// -----------------------------------------------------------------------------
module osc_intl_multi #(
  parameter int CH_NUM    = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_osc_en,
  input  logic                    i_clr,
  input  logic [32*CH_NUM-1:0]    i_data,
  input  logic [32*CH_NUM-1:0]    i_data_thresh,
  input  logic [CNT_WIDTH-1:0]    i_cnt_thresh,
  input  logic [CNT_WIDTH-1:0]    i_period,
  input  logic [CNT_WIDTH-1:0]    i_cycle_cnt,
  output logic [CH_NUM-1:0]       o_intl,
`ifdef OSC_FIRST_FAULT_EN
  output logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] o_first_ch,
  output logic                    o_first_vld,
`endif
  output logic                    o_intl_any
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Counters stop at all-ones instead of wrapping back to 0.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // ---------------------------------------------------------------------------
  // Magnitude compare
  // The IEEE-754 sign bit is dropped. For non-negative floats, bits [30:0]
  // order the same way as the values, so an unsigned compare gives |x| > |t|.
  // A NaN sample (exp all ones, mantissa non-zero) always counts as exceeding.
  // ---------------------------------------------------------------------------
  logic [CH_NUM-1:0]   exc_now;
  logic [2*CH_NUM-1:0] sign_unused;

  always_comb begin
    exc_now     = '0;
    sign_unused = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      exc_now[k] = ((i_data[32*k+30 -: 8] == 8'hFF) && (i_data[32*k+22 -: 23] != 23'd0))
                || (i_data[32*k +: 31] > i_data_thresh[32*k +: 31]);
      sign_unused[2*k]   = i_data[32*k+31];
      sign_unused[2*k+1] = i_data_thresh[32*k+31];
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CH_NUM-1:0]    exc_q;            // registered compare result
  logic [CH_NUM-1:0]    edge_q, edge_d;   // previous exc_q, for 0->1 detection
  logic [CNT_WIDTH-1:0] win_q, win_d;     // shared window position
  logic [CNT_WIDTH-1:0] evt_q [CH_NUM];   // crossings in current window
  logic [CNT_WIDTH-1:0] evt_d [CH_NUM];
  logic [CNT_WIDTH-1:0] hit_q [CH_NUM];   // consecutive hit windows
  logic [CNT_WIDTH-1:0] hit_d [CH_NUM];
  logic [CNT_WIDTH-1:0] per_q, per_d;     // config in force for this window
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic                 clr_q;            // i_clr history for edge detect
  logic [CH_NUM-1:0]    intl_q, intl_d;
  logic                 any_q;

  logic                 run;
  logic                 wrap;
  logic                 cfg_load;
  logic                 clr_edge;
  logic [CNT_WIDTH-1:0] cyc_eff;
  logic [CH_NUM-1:0]    evt_pulse;
  logic [CH_NUM-1:0]    trip;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // Detection runs only while enabled and the config in force is valid.
  // The config registers reload every clock while detection is idle, and at
  // each wrap while it runs. A mid-window config change therefore waits for
  // the wrap. Once idle, the detector restarts from the live inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    run       = i_osc_en && (per_q != '0) && (cnt_q != '0);
    wrap      = run && (win_q == per_q - CNT_ONE);
    cfg_load  = !run || wrap;
    clr_edge  = i_clr && !clr_q;
    cyc_eff   = (cyc_q == '0) ? CNT_ONE : cyc_q;
    evt_pulse = exc_q & ~edge_q;

    per_d  = cfg_load ? i_period     : per_q;
    cnt_d  = cfg_load ? i_cnt_thresh : cnt_q;
    cyc_d  = cfg_load ? i_cycle_cnt  : cyc_q;
    edge_d = run ? exc_q : '0;

    if (!run || wrap) begin
      win_d = '0;
    end else begin
      win_d = win_q + CNT_ONE;
    end

    for (int k = 0; k < CH_NUM; k++) begin
      if (!run) begin
        evt_d[k] = '0;
        hit_d[k] = '0;
      end else if (wrap) begin
        // A crossing in the wrap clock belongs to the new window.
        evt_d[k] = CNT_WIDTH'(evt_pulse[k]);
        hit_d[k] = (evt_q[k] >= cnt_q) ? sat_inc(hit_q[k]) : '0;
      end else begin
        evt_d[k] = evt_pulse[k] ? sat_inc(evt_q[k]) : evt_q[k];
        hit_d[k] = hit_q[k];
      end
      if (clr_edge) begin
        hit_d[k] = '0;
      end
      trip[k] = (hit_q[k] >= cyc_eff);
    end

    // A trip in the same clock as a clear edge wins.
    intl_d = (intl_q & ~{CH_NUM{clr_edge}}) | trip;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      exc_q  <= '0;
      edge_q <= '0;
      win_q  <= '0;
      per_q  <= '0;
      cnt_q  <= '0;
      cyc_q  <= '0;
      clr_q  <= 1'b0;
      intl_q <= '0;
      any_q  <= 1'b0;
      for (int k = 0; k < CH_NUM; k++) begin
        evt_q[k] <= '0;
        hit_q[k] <= '0;
      end
    end else begin
      exc_q  <= exc_now;
      edge_q <= edge_d;
      win_q  <= win_d;
      per_q  <= per_d;
      cnt_q  <= cnt_d;
      cyc_q  <= cyc_d;
      clr_q  <= i_clr;
      intl_q <= intl_d;
      any_q  <= |intl_q;
      for (int k = 0; k < CH_NUM; k++) begin
        evt_q[k] <= evt_d[k];
        hit_q[k] <= hit_d[k];
      end
    end
  end

  assign o_intl     = intl_q;
  assign o_intl_any = any_q;

`ifdef OSC_FIRST_FAULT_EN
  // ---------------------------------------------------------------------------
  // First-fault capture: the lowest channel that trips while none is captured.
  // A clear edge frees the capture. A trip in that same clock is captured at once.
  // ---------------------------------------------------------------------------
  localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic [IDX_W-1:0] first_ch_q, first_ch_d, trip_idx;
  logic             first_vld_q, first_vld_d;

  always_comb begin
    trip_idx = '0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (trip[k]) begin
        trip_idx = IDX_W'(k);
      end
    end
    first_ch_d  = first_ch_q;
    first_vld_d = first_vld_q;
    if (clr_edge) begin
      first_ch_d  = '0;
      first_vld_d = 1'b0;
    end
    if ((|trip) && !first_vld_d) begin
      first_ch_d  = trip_idx;
      first_vld_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      first_ch_q  <= '0;
      first_vld_q <= 1'b0;
    end else begin
      first_ch_q  <= first_ch_d;
      first_vld_q <= first_vld_d;
    end
  end

  assign o_first_ch  = first_ch_q;
  assign o_first_vld = first_vld_q;
`endif

endmodule
